pe_dbuf: RTL and testbench

- Next-generation systolic processing element for the matrix-multiply array.
- Supports two dataflow modes:
  - weight-stationary (WS), with a double-buffered weight so the next tile's weights shift in while the current tile computes;
  - output-stationary (OS), accumulating locally and draining through the sum chain.
- Adds valid qualification, selectable signed/unsigned arithmetic and optional saturation.
- Tiles as a 2-D grid: activations flow left→right, weights and sums flow top→bottom.

---
 rtl/pe_pkg.sv | 49 ++++
 rtl/pe_mac_sat.sv | 62 ++++++
 rtl/pe_dbuf.sv | 146 ++++++++++++++
 tb/tb_pe_dbuf.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the pe_dbuf systolic processing element.
//   MODE_WS / MODE_OS : values of the pe_dbuf 'mode' input.
//   SAT_MAX_W         : widest result the saturating-add helper can handle.
//   sat_add()         : width-generic saturating add. It is only used when
//                       PE_DBUF_SATURATE_EN is defined.
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  localparam int SAT_MAX_W = 64;

  // Adds two 'width'-bit values carried in the low bits of SAT_MAX_W-bit
  // containers. The upper bits of both containers must be zero. The sum is
  // clamped to the signed or unsigned range of 'width' bits.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          width,
    input logic                 is_signed
  );
    logic [SAT_MAX_W:0] one;
    logic [SAT_MAX_W:0] mask;
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] sum_w;
    logic [SAT_MAX_W:0] pos_max;
    logic [SAT_MAX_W:0] neg_min;
    one     = {{SAT_MAX_W{1'b0}}, 1'b1};
    mask    = (one << width) - one;
    full    = {1'b0, a} + {1'b0, b};
    sum_w   = full & mask;
    pos_max = (one << (width - 1)) - one;
    neg_min = one << (width - 1);
    if (is_signed) begin
      // Signed overflow: both operands have the same sign and the result
      // has the other sign.
      if ((a[width-1] == b[width-1]) && (full[width-1] != a[width-1])) begin
        sum_w = a[width-1] ? neg_min : pos_max;
      end
    end else if (full[width]) begin
      sum_w = mask;
    end
    return sum_w[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// -----------------------------------------------------------------------------
// pe_mac_sat
// Combinational multiply-accumulate datapath shared by both dataflow modes.
// It computes result = addend + ext(a * b).
//   - The product is full 2*DATA_WIDTH bits wide.
//   - ext() sign-extends the product when SIGNED != 0 and zero-extends it
//     otherwise.
//   - The add wraps modulo 2^RESULT_WIDTH. When the macro PE_DBUF_SATURATE_EN
//     is defined, the add instead clamps to the range of the result type.
// Ports:
//   a      [DATA_WIDTH]   activation operand
//   b      [DATA_WIDTH]   weight operand
//   addend [RESULT_WIDTH] value the product is added to
//   result [RESULT_WIDTH] sum
// -----------------------------------------------------------------------------
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int SIGNED       = 1
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [RESULT_WIDTH-1:0] addend,
  output logic [RESULT_WIDTH-1:0] result
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]           a_ext;
  logic [PW-1:0]           b_ext;
  logic [PW-1:0]           product;
  logic [RESULT_WIDTH-1:0] product_ext;

  // Both operands are widened to the product width before the multiply, so
  // the low PW bits of the multiply hold the exact full-width product.
  if (SIGNED != 0) begin : g_signed
    logic signed [RESULT_WIDTH-1:0] product_sext;
    assign a_ext        = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign b_ext        = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign product_sext = $signed(product);
    assign product_ext  = product_sext;
  end else begin : g_unsigned
    assign a_ext       = {{DATA_WIDTH{1'b0}}, a};
    assign b_ext       = {{DATA_WIDTH{1'b0}}, b};
    assign product_ext = RESULT_WIDTH'(product);
  end

  assign product = a_ext * b_ext;

`ifdef PE_DBUF_SATURATE_EN
  if (RESULT_WIDTH > SAT_MAX_W) begin : g_sat_width_check
    $error("pe_mac_sat: RESULT_WIDTH exceeds saturating adder width");
  end
  assign result = RESULT_WIDTH'(sat_add(SAT_MAX_W'(addend), SAT_MAX_W'(product_ext),
                                        RESULT_WIDTH, SIGNED != 0));
`else
  assign result = addend + product_ext;
`endif

endmodule

// File: rtl/pe_dbuf.sv
// -----------------------------------------------------------------------------
// pe_dbuf
// Systolic processing element for the matrix-multiply array. It supports two
// dataflow modes:
//   - Weight-stationary (WS). The weight is double-buffered: a shadow weight
//     is loaded while the active weight is used, then swapped in.
//   - Output-stationary (OS). The PE accumulates locally and drains through
//     the sum chain.
// Activations move left to right. Weights and sums move top to bottom.
//
// Optional build macro:
//   PE_DBUF_SATURATE_EN : WS sums and OS accumulates clamp on overflow
//                         instead of wrapping.
//
// Ports:
//   clk, reset (async, active-low), enable (0 = freeze everything)
//   mode           0 = WS, 1 = OS
//   weight_shift   WS: shadow <= weight_in
//   weight_swap    WS: active <= shadow
//   acc_clear      OS: zero accumulator (clear-and-load when an activation is valid)
//   drain          OS: drive accumulator onto the sum chain
//   weight_in / weight_out                 weight chain (1-cycle register)
//   activ_valid_in, activ_input            activation from the left
//   activ_valid_out, activ_output          registered activation to the right
//   sum_valid_in, top_sum_input            partial sum from above
//   sum_valid_out, sum_output              registered sum to the PE below
// -----------------------------------------------------------------------------
module pe_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int SIGNED       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    weight_shift,
  input  logic                    weight_swap,
  input  logic                    acc_clear,
  input  logic                    drain,
  input  logic [DATA_WIDTH-1:0]   weight_in,
  output logic [DATA_WIDTH-1:0]   weight_out,
  input  logic                    activ_valid_in,
  input  logic [DATA_WIDTH-1:0]   activ_input,
  output logic                    activ_valid_out,
  output logic [DATA_WIDTH-1:0]   activ_output,
  input  logic                    sum_valid_in,
  input  logic [RESULT_WIDTH-1:0] top_sum_input,
  output logic                    sum_valid_out,
  output logic [RESULT_WIDTH-1:0] sum_output
);

  if (RESULT_WIDTH < 2 * DATA_WIDTH) begin : g_width_check
    $error("pe_dbuf: RESULT_WIDTH must be at least 2*DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0]   weight_out_reg;
  logic [DATA_WIDTH-1:0]   activ_output_reg;
  logic                    activ_valid_out_reg;
  logic [DATA_WIDTH-1:0]   shadow_weight_reg;
  logic [DATA_WIDTH-1:0]   active_weight_reg;
  logic [RESULT_WIDTH-1:0] acc_reg;
  logic [RESULT_WIDTH-1:0] sum_output_reg;
  logic                    sum_valid_out_reg;

  logic [DATA_WIDTH-1:0]   mac_b;
  logic [RESULT_WIDTH-1:0] mac_addend;
  logic [RESULT_WIDTH-1:0] mac_result;

  // One MAC serves both modes, with its operands muxed by mode:
  //   WS : top_sum_input + activ * active weight
  //   OS : acc + activ * weight_in. The addend is forced to zero during
  //        acc_clear, so a clear with a valid activation loads the product.
  always_comb begin
    mac_b      = active_weight_reg;
    mac_addend = top_sum_input;
    if (mode == MODE_OS) begin
      mac_b      = weight_in;
      mac_addend = acc_clear ? '0 : acc_reg;
    end
  end

  pe_mac_sat #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RESULT_WIDTH (RESULT_WIDTH),
    .SIGNED       (SIGNED)
  ) u_mac (
    .a      (activ_input),
    .b      (mac_b),
    .addend (mac_addend),
    .result (mac_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight_out_reg      <= '0;
      activ_output_reg    <= '0;
      activ_valid_out_reg <= 1'b0;
      shadow_weight_reg   <= '0;
      active_weight_reg   <= '0;
      acc_reg             <= '0;
      sum_output_reg      <= '0;
      sum_valid_out_reg   <= 1'b0;
    end else if (enable) begin
      activ_output_reg    <= activ_input;
      activ_valid_out_reg <= activ_valid_in;
      weight_out_reg      <= weight_in;

      if (mode == MODE_WS) begin
        // Nonblocking updates let shift and swap coexist: the active weight
        // takes the old shadow while the shadow takes weight_in.
        if (weight_shift) shadow_weight_reg <= weight_in;
        if (weight_swap)  active_weight_reg <= shadow_weight_reg;
        if (activ_valid_in) begin
          sum_output_reg    <= mac_result;
          sum_valid_out_reg <= 1'b1;
        end else begin
          sum_valid_out_reg <= 1'b0;
        end
      end else begin
        if (activ_valid_in) begin
          acc_reg <= mac_result;
        end else if (acc_clear) begin
          acc_reg <= '0;
        end
        // Drain presents the accumulator as it was before this cycle's update.
        if (drain) begin
          sum_output_reg    <= acc_reg;
          sum_valid_out_reg <= 1'b1;
        end else begin
          sum_output_reg    <= top_sum_input;
          sum_valid_out_reg <= sum_valid_in;
        end
      end
    end
  end

  assign weight_out      = weight_out_reg;
  assign activ_output    = activ_output_reg;
  assign activ_valid_out = activ_valid_out_reg;
  assign sum_output      = sum_output_reg;
  assign sum_valid_out   = sum_valid_out_reg;

endmodule

// File: tb/tb_pe_dbuf.sv
// -----------------------------------------------------------------------------
// tb_pe_dbuf
// Self-checking bench for pe_dbuf. Three instances share one stimulus:
//   u_dut0 : DATA_WIDTH=8, RESULT_WIDTH=32, SIGNED=1
//   u_dut1 : DATA_WIDTH=8, RESULT_WIDTH=32, SIGNED=0
//   u_dut2 : DATA_WIDTH=8, RESULT_WIDTH=16, SIGNED=1
// Directed scenarios are followed by a randomized run. The randomized run is
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pe_dbuf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        weight_shift = 1'b0;
  logic        weight_swap = 1'b0;
  logic        acc_clear = 1'b0;
  logic        drain = 1'b0;
  logic [7:0]  weight_in = '0;
  logic        activ_valid_in = 1'b0;
  logic [7:0]  activ_input = '0;
  logic        sum_valid_in = 1'b0;
  logic [31:0] top_sum_input = '0;

  logic [7:0]  wout0, wout1, wout2, aout0, aout1, aout2;
  logic        avout0, avout1, avout2, svout0, svout1, svout2;
  logic [31:0] sum0, sum1;
  logic [15:0] sum2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_dbuf #(.DATA_WIDTH(8), .RESULT_WIDTH(32), .SIGNED(1)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .weight_shift(weight_shift), .weight_swap(weight_swap),
    .acc_clear(acc_clear), .drain(drain),
    .weight_in(weight_in), .weight_out(wout0),
    .activ_valid_in(activ_valid_in), .activ_input(activ_input),
    .activ_valid_out(avout0), .activ_output(aout0),
    .sum_valid_in(sum_valid_in), .top_sum_input(top_sum_input),
    .sum_valid_out(svout0), .sum_output(sum0));

  pe_dbuf #(.DATA_WIDTH(8), .RESULT_WIDTH(32), .SIGNED(0)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .weight_shift(weight_shift), .weight_swap(weight_swap),
    .acc_clear(acc_clear), .drain(drain),
    .weight_in(weight_in), .weight_out(wout1),
    .activ_valid_in(activ_valid_in), .activ_input(activ_input),
    .activ_valid_out(avout1), .activ_output(aout1),
    .sum_valid_in(sum_valid_in), .top_sum_input(top_sum_input),
    .sum_valid_out(svout1), .sum_output(sum1));

  pe_dbuf #(.DATA_WIDTH(8), .RESULT_WIDTH(16), .SIGNED(1)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .weight_shift(weight_shift), .weight_swap(weight_swap),
    .acc_clear(acc_clear), .drain(drain),
    .weight_in(weight_in), .weight_out(wout2),
    .activ_valid_in(activ_valid_in), .activ_input(activ_input),
    .activ_valid_out(avout2), .activ_output(aout2),
    .sum_valid_in(sum_valid_in), .top_sum_input(top_sum_input[15:0]),
    .sum_valid_out(svout2), .sum_output(sum2));

  // ---------------- reference model state ----------------
  int     rw [3] = '{32, 32, 16};
  bit     sg [3] = '{1'b1, 1'b0, 1'b1};
  longint m_shadow [3];
  longint m_active [3];
  longint m_acc    [3];
  longint m_sum    [3];
  bit     m_sv     [3];
  longint m_wout, m_aout;
  bit     m_avout;

  function automatic longint mask_of(int w);
    return (longint'(1) << w) - 1;
  endfunction

  // Numeric value of a w-bit pattern.
  function automatic longint interp(longint bits, int w, bit s);
    if (s && bits[w-1]) return bits - (longint'(1) << w);
    return bits;
  endfunction

  // Bring an exact sum back into w-bit storage (clamping when saturation is built in).
  function automatic longint fit(longint v, int w, bit s);
    longint r;
    r = v;
`ifdef PE_DBUF_SATURATE_EN
    if (s) begin
      if (r > (longint'(1) << (w-1)) - 1) r = (longint'(1) << (w-1)) - 1;
      if (r < -(longint'(1) << (w-1)))    r = -(longint'(1) << (w-1));
    end else begin
      if (r > mask_of(w)) r = mask_of(w);
      if (r < 0)          r = 0;
    end
`endif
    return r & mask_of(w);
  endfunction

  function automatic longint got_sum(int k);
    case (k)
      0:       return longint'(sum0);
      1:       return longint'(sum1);
      default: return longint'(sum2);
    endcase
  endfunction

  function automatic bit got_sv(int k);
    case (k)
      0:       return svout0;
      1:       return svout1;
      default: return svout2;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_shadow[k] = 0; m_active[k] = 0; m_acc[k] = 0; m_sum[k] = 0; m_sv[k] = 0;
    end
    m_wout = 0; m_aout = 0; m_avout = 0;
  endtask

  // Apply one clock edge of behaviour using the inputs currently driven.
  task automatic model_step();
    longint a, b, top, prod, old_acc;
    if (!enable) return;
    m_aout  = activ_input;
    m_avout = activ_valid_in;
    m_wout  = weight_in;
    for (int k = 0; k < 3; k++) begin
      a   = interp(longint'(activ_input), 8, sg[k]);
      top = interp(longint'(top_sum_input) & mask_of(rw[k]), rw[k], sg[k]);
      if (!mode) begin
        prod = a * interp(m_active[k], 8, sg[k]);
        if (activ_valid_in) begin
          m_sum[k] = fit(top + prod, rw[k], sg[k]);
          m_sv[k]  = 1;
        end else begin
          m_sv[k]  = 0;
        end
        if (weight_swap)  m_active[k] = m_shadow[k];
        if (weight_shift) m_shadow[k] = weight_in;
      end else begin
        prod    = a * interp(longint'(weight_in), 8, sg[k]);
        old_acc = m_acc[k];
        if (activ_valid_in)
          m_acc[k] = fit((acc_clear ? 0 : interp(old_acc, rw[k], sg[k])) + prod, rw[k], sg[k]);
        else if (acc_clear)
          m_acc[k] = 0;
        if (drain) begin
          m_sum[k] = old_acc;
          m_sv[k]  = 1;
        end else begin
          m_sum[k] = longint'(top_sum_input) & mask_of(rw[k]);
          m_sv[k]  = sum_valid_in;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    weight_shift = 0; weight_swap = 0; acc_clear = 0; drain = 0;
    activ_valid_in = 0; sum_valid_in = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    #2;
    reset = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_cmp++;
    if ({wout0, aout0, avout0, svout0, sum0} !== '0) begin
      n_bad++; $display("FAIL reset_state: got %0h required 0", {wout0, aout0, avout0, svout0, sum0});
    end
    reset = 1; enable = 1; mode = 0;
    activ_input = 8'h11; activ_valid_in = 1; weight_in = 8'h22; top_sum_input = 32'd5;
    step();
    step();
    n_cmp++;
    if (aout0 !== 8'h11 || wout0 !== 8'h22 || sum0 !== 32'd5 || svout0 !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_load: got a=%0h w=%0h s=%0h v=%0b required a=11 w=22 s=5 v=1",
                        aout0, wout0, sum0, svout0);
    end
    #3;
    reset = 0;
    #1;
    n_cmp++;
    if ({wout0, aout0, avout0, svout0, sum0} !== '0 || sum2 !== 16'd0 || sum1 !== 32'd0) begin
      n_bad++; $display("FAIL async_reset: got %0h required 0", {wout0, aout0, avout0, svout0, sum0});
    end
    reset = 1;
    idle_inputs();
    $display("test_reset done");
  endtask

  task automatic test_hold();
    step();
    mode = 0; activ_valid_in = 1; activ_input = 8'h5A; weight_in = 8'h33; top_sum_input = 32'd123;
    step();
    enable = 0;
    for (int c = 0; c < 5; c++) begin
      activ_input = 8'($urandom); weight_in = 8'($urandom); top_sum_input = $urandom;
      weight_shift = 1; weight_swap = 1; activ_valid_in = 0; mode = 1'($urandom);
      acc_clear = 1; drain = 1; sum_valid_in = 1;
      step();
      n_cmp++;
      if (aout0 !== 8'h5A || avout0 !== 1'b1 || wout0 !== 8'h33 || sum0 !== 32'd123 || svout0 !== 1'b1) begin
        n_bad++; $display("FAIL hold_c%0d: got a=%0h av=%0b w=%0h s=%0d v=%0b required 5a 1 33 123 1",
                          c, aout0, avout0, wout0, sum0, svout0);
      end
    end
    enable = 1; mode = 0;
    idle_inputs();
    $display("test_hold done");
  endtask

  task automatic test_ws_double_buffer();
    mode = 0; idle_inputs();
    weight_shift = 1; weight_in = 8'd3; step();
    weight_shift = 0; weight_swap = 1; weight_in = 8'd0; step();
    weight_swap = 0; weight_shift = 1; weight_in = 8'd7; step();
    n_cmp++;
    if (wout0 !== 8'd7) begin
      n_bad++; $display("FAIL ws_weight_out: got %0d required 7", wout0);
    end
    weight_shift = 0; activ_valid_in = 1; activ_input = 8'd5; top_sum_input = 32'd10; step();
    n_cmp++;
    if (sum0 !== 32'd25 || svout0 !== 1'b1) begin
      n_bad++; $display("FAIL ws_sum_25: got %0d/%0b required 25/1", sum0, svout0);
    end
    activ_valid_in = 0; weight_swap = 1; step();
    n_cmp++;
    if (sum0 !== 32'd25 || svout0 !== 1'b0) begin
      n_bad++; $display("FAIL ws_invalid_hold: got %0d/%0b required 25/0", sum0, svout0);
    end
    weight_swap = 0; activ_valid_in = 1; activ_input = 8'd2; top_sum_input = 32'd1; step();
    n_cmp++;
    if (sum0 !== 32'd15) begin
      n_bad++; $display("FAIL ws_sum_15: got %0d required 15", sum0);
    end
    idle_inputs();
    $display("test_ws_double_buffer done");
  endtask

  task automatic test_ws_shift_swap();
    mode = 0; idle_inputs();
    weight_shift = 1; weight_in = 8'd4; step();
    weight_shift = 1; weight_swap = 1; weight_in = 8'd9; step();
    weight_shift = 0; weight_swap = 0;
    activ_valid_in = 1; activ_input = 8'd1; top_sum_input = 32'd0; step();
    n_cmp++;
    if (sum0 !== 32'd4) begin
      n_bad++; $display("FAIL ws_shift_swap_old: got %0d required 4", sum0);
    end
    activ_valid_in = 0; weight_swap = 1; step();
    weight_swap = 0; activ_valid_in = 1; step();
    n_cmp++;
    if (sum0 !== 32'd9) begin
      n_bad++; $display("FAIL ws_shift_swap_new: got %0d required 9", sum0);
    end
    idle_inputs();
    $display("test_ws_shift_swap done");
  endtask

  task automatic test_os();
    mode = 1; idle_inputs(); top_sum_input = 0;
    acc_clear = 1; activ_valid_in = 1; activ_input = 8'd2; weight_in = 8'd3; step();
    acc_clear = 0; activ_input = 8'd4; weight_in = 8'd5; step();
    activ_input = 8'hFF; weight_in = 8'd6; step();
    activ_valid_in = 0; drain = 1; step();
    n_cmp++;
    if (sum0 !== 32'd20 || svout0 !== 1'b1) begin
      n_bad++; $display("FAIL os_drain: got %0d/%0b required 20/1", sum0, svout0);
    end
    drain = 0; top_sum_input = 32'd77; sum_valid_in = 1; step();
    n_cmp++;
    if (sum0 !== 32'd77 || svout0 !== 1'b1) begin
      n_bad++; $display("FAIL os_chain: got %0d/%0b required 77/1", sum0, svout0);
    end
    // The weights loaded in WS mode must survive OS operation with shift/swap asserted.
    weight_shift = 1; weight_swap = 1; sum_valid_in = 0; step();
    mode = 0; idle_inputs(); activ_valid_in = 1; activ_input = 8'd1; top_sum_input = 0; step();
    n_cmp++;
    if (sum0 !== 32'd9) begin
      n_bad++; $display("FAIL os_weights_kept: got %0d required 9", sum0);
    end
    idle_inputs();
    $display("test_os done");
  endtask

  task automatic test_unsigned();
    mode = 0; idle_inputs();
    weight_shift = 1; weight_in = 8'd255; step();
    weight_shift = 0; weight_swap = 1; step();
    weight_swap = 0; activ_valid_in = 1; activ_input = 8'd255; top_sum_input = 0; step();
    n_cmp++;
    if (sum1 !== 32'd65025) begin
      n_bad++; $display("FAIL unsigned_mul: got %0d required 65025", sum1);
    end
    n_cmp++;
    if (sum0 !== 32'd1) begin
      n_bad++; $display("FAIL signed_neg_mul: got %0d required 1", sum0);
    end
    idle_inputs();
    $display("test_unsigned done");
  endtask

  task automatic test_overflow();
    logic [15:0] exp2;
`ifdef PE_DBUF_SATURATE_EN
    exp2 = 16'h7FFF;
`else
    exp2 = 16'h8000;
`endif
    mode = 0; idle_inputs();
    weight_shift = 1; weight_in = 8'd1; step();
    weight_shift = 0; weight_swap = 1; step();
    weight_swap = 0; activ_valid_in = 1; activ_input = 8'd1; top_sum_input = 32'd32767; step();
    n_cmp++;
    if (sum2 !== exp2) begin
      n_bad++; $display("FAIL overflow16: got %0h required %0h", sum2, exp2);
    end
    n_cmp++;
    if (sum0 !== 32'd32768) begin
      n_bad++; $display("FAIL no_overflow32: got %0d required 32768", sum0);
    end
    idle_inputs();
    $display("test_overflow done");
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_bad;
    idle_inputs();
    do_reset();
    model_reset();
    enable = 1; mode = 0;
    for (int c = 0; c < 400; c++) begin
      enable         = ($urandom_range(99) < 85);
      if ($urandom_range(99) < 6) mode = ~mode;
      weight_shift   = ($urandom_range(99) < 30);
      weight_swap    = ($urandom_range(99) < 20);
      acc_clear      = ($urandom_range(99) < 15);
      drain          = ($urandom_range(99) < 20);
      activ_valid_in = ($urandom_range(99) < 60);
      sum_valid_in   = 1'($urandom);
      activ_input    = 8'($urandom);
      weight_in      = 8'($urandom);
      top_sum_input  = ($urandom_range(3) == 0) ? 32'h7FFF_FF00 + 32'($urandom_range(255)) : $urandom;
      model_step();
      step();
      n_cmp++;
      if (longint'(aout0) !== m_aout || avout0 !== m_avout || longint'(wout0) !== m_wout) begin
        n_bad++; $display("FAIL rand_pass_c%0d: got a=%0h av=%0b w=%0h required a=%0h av=%0b w=%0h",
                          c, aout0, avout0, wout0, m_aout, m_avout, m_wout);
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (got_sum(k) !== m_sum[k] || got_sv(k) !== m_sv[k]) begin
          n_bad++; $display("FAIL rand_sum_c%0d_dut%0d: got %0h/%0b required %0h/%0b",
                            c, k, got_sum(k), got_sv(k), m_sum[k], m_sv[k]);
        end
      end
    end
    idle_inputs(); enable = 1;
    $display("test_random done: %0d new mismatches", n_bad - errs_before);
  endtask

  initial begin
    test_reset();
    test_hold();
    test_ws_double_buffer();
    test_ws_shift_swap();
    test_os();
    test_unsigned();
    test_overflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
